awgn_stats_monitor: RTL

//  Consumer end of the Box-Muller AWGN generator sample interface (x_en/x0/x1).

---
 rtl/awgn_stats_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/awgn_stats_monitor.sv
// Window statistics on the AWGN generator sample stream: per-channel mean,
// combined mean-square, peak |x| and clip count over 2^LOG2_N sample pairs.
module awgn_stats_monitor #(
    parameter int          LOG2_N  = 10,
    parameter logic [15:0] CLIP_TH = 16'd16384
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              x_en,
    input  logic [15:0]       x0,
    input  logic [15:0]       x1,
    output logic              busy,
    output logic              done,
    output logic [15:0]       mean0,
    output logic [15:0]       mean1,
    output logic [31:0]       msq,
    output logic [15:0]       peak,
    output logic [LOG2_N+1:0] clip_cnt
);
    localparam int SW = 16 + LOG2_N;
    localparam int QW = 32 + LOG2_N;
    localparam int CW = LOG2_N + 2;
    localparam logic [LOG2_N:0] LAST = {1'b0, {LOG2_N{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FINISH} state_t;
    state_t state, state_nxt;

    logic [LOG2_N:0] pair_cnt;
    logic [1:0]      drain_cnt;
    logic            start_ok, accept, last_pair;

    // done cycle already has state==IDLE, so it still counts as busy
    assign busy      = (state != IDLE) || done;
    assign start_ok  = start && (state == IDLE) && !done;
    assign accept    = (state == ACCUM) && x_en;
    assign last_pair = accept && (pair_cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACCUM;
            ACCUM:   if (last_pair) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pair_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (start_ok)
                pair_cnt <= '0;
            else if (accept)
                pair_cnt <= pair_cnt + 1'b1;
        end
    end

    // S1: capture
    logic               s1_vld;
    logic signed [15:0] s1_x0, s1_x1;
    // S2: square and magnitude
    logic               s2_vld;
    logic signed [15:0] s2_x0, s2_x1;
    logic [31:0]        s2_sq0, s2_sq1;
    logic [15:0]        s2_abs0, s2_abs1;
    logic signed [31:0] p0, p1;
    logic [15:0]        a0, a1;

    assign p0 = s1_x0 * s1_x0;
    assign p1 = s1_x1 * s1_x1;
    // two's-complement negate keeps -32768 as 16'h8000 read unsigned
    assign a0 = s1_x0[15] ? (~s1_x0 + 16'd1) : s1_x0;
    assign a1 = s1_x1[15] ? (~s1_x1 + 16'd1) : s1_x1;

    // S3: accumulators
    logic signed [SW-1:0] sum0, sum1;
    logic [QW-1:0]        sumsq;
    logic [15:0]          peak_acc, pk2;
    logic [CW-1:0]        clip_acc;

    assign pk2 = (s2_abs0 > s2_abs1) ? s2_abs0 : s2_abs1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;  s1_x0   <= '0;  s1_x1   <= '0;
            s2_vld   <= 1'b0;  s2_x0   <= '0;  s2_x1   <= '0;
            s2_sq0   <= '0;    s2_sq1  <= '0;
            s2_abs0  <= '0;    s2_abs1 <= '0;
            sum0     <= '0;    sum1    <= '0;  sumsq   <= '0;
            peak_acc <= '0;    clip_acc <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_x0 <= x0;
                s1_x1 <= x1;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_x0   <= s1_x0;
                s2_x1   <= s1_x1;
                s2_sq0  <= p0;
                s2_sq1  <= p1;
                s2_abs0 <= a0;
                s2_abs1 <= a1;
            end
            if (start_ok) begin
                sum0     <= '0;
                sum1     <= '0;
                sumsq    <= '0;
                peak_acc <= '0;
                clip_acc <= '0;
            end else if (s2_vld) begin
                sum0     <= sum0 + SW'(s2_x0);
                sum1     <= sum1 + SW'(s2_x1);
                sumsq    <= sumsq + QW'(s2_sq0) + QW'(s2_sq1);
                if (pk2 > peak_acc)
                    peak_acc <= pk2;
                clip_acc <= clip_acc + CW'(s2_abs0 >= CLIP_TH) + CW'(s2_abs1 >= CLIP_TH);
            end
        end
    end

    // results latched leaving FINISH; done high 4 edges after the last pair
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            mean0    <= '0;
            mean1    <= '0;
            msq      <= '0;
            peak     <= '0;
            clip_cnt <= '0;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) begin
                mean0    <= 16'(sum0 >>> LOG2_N);
                mean1    <= 16'(sum1 >>> LOG2_N);
                msq      <= 32'(sumsq >> (LOG2_N + 1));
                peak     <= peak_acc;
                clip_cnt <= clip_acc;
            end
        end
    end
endmodule
